// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU in the Execute stage.
// Requests a pipeline stall while iterating and abandons the operation on an E-stage flush.
module div_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  E_DivStart,
    input  logic [1:0]            E_DivOp,
    input  logic [DATA_WIDTH-1:0] E_SrcA,
    input  logic [DATA_WIDTH-1:0] E_SrcB,
    input  logic                  E_Flush,
    output logic                  E_DivStall,
    output logic                  E_DivDone,
    output logic [DATA_WIDTH-1:0] E_DivResult
);

    localparam logic [DATA_WIDTH-1:0] INT_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] ALL_ONES = '1;
    localparam logic [CNT_WIDTH-1:0]  LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                  state;
    logic [CNT_WIDTH-1:0]    cnt;
    logic [DATA_WIDTH-1:0]   quo;
    logic [DATA_WIDTH-1:0]   rem;
    logic [DATA_WIDTH-1:0]   dvsr;
    logic                    is_rem;
    logic                    quo_neg;
    logic                    rem_neg;
    logic [DATA_WIDTH-1:0]   result;

    // Operand decode for the start cycle
    logic                    op_signed;
    logic                    a_neg;
    logic                    b_neg;
    logic [DATA_WIDTH-1:0]   a_mag;
    logic [DATA_WIDTH-1:0]   b_mag;
    logic                    div_zero;
    logic                    overflow;
    logic [DATA_WIDTH-1:0]   special_res;

    assign op_signed   = ~E_DivOp[0];
    assign a_neg       = op_signed & E_SrcA[DATA_WIDTH-1];
    assign b_neg       = op_signed & E_SrcB[DATA_WIDTH-1];
    assign a_mag       = a_neg ? -E_SrcA : E_SrcA;
    assign b_mag       = b_neg ? -E_SrcB : E_SrcB;
    assign div_zero    = (E_SrcB == '0);
    assign overflow    = op_signed & (E_SrcA == INT_MIN) & (E_SrcB == ALL_ONES);
    assign special_res = div_zero ? (E_DivOp[1] ? E_SrcA : ALL_ONES)
                                  : (E_DivOp[1] ? '0     : INT_MIN);

    // One restoring step. The partial remainder is always below the divisor, so a set
    // top bit after the shift already guarantees the subtraction fits.
    logic [DATA_WIDTH:0]     rem_sh;
    logic [DATA_WIDTH:0]     diff;
    logic                    fits;
    logic [DATA_WIDTH-1:0]   rem_nxt;
    logic [DATA_WIDTH-1:0]   quo_nxt;
    logic [DATA_WIDTH-1:0]   final_res;

    assign rem_sh    = {rem, quo[DATA_WIDTH-1]};
    assign diff      = rem_sh - {1'b0, dvsr};
    assign fits      = rem_sh[DATA_WIDTH] | ~diff[DATA_WIDTH];
    assign rem_nxt   = fits ? diff[DATA_WIDTH-1:0] : rem_sh[DATA_WIDTH-1:0];
    assign quo_nxt   = {quo[DATA_WIDTH-2:0], fits};
    assign final_res = is_rem ? (rem_neg ? -rem_nxt : rem_nxt)
                              : (quo_neg ? -quo_nxt : quo_nxt);

    // NOTE: all state below is updated with non-blocking assignments so every register
    // samples the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            quo     <= '0;
            rem     <= '0;
            dvsr    <= '0;
            is_rem  <= 1'b0;
            quo_neg <= 1'b0;
            rem_neg <= 1'b0;
            result  <= '0;
        end else if (E_Flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (E_DivStart) begin
                        is_rem  <= E_DivOp[1];
                        quo_neg <= a_neg ^ b_neg;
                        rem_neg <= a_neg;
                        dvsr    <= b_mag;
                        quo     <= a_mag;
                        rem     <= '0;
                        cnt     <= '0;
                        if (div_zero || overflow) begin
                            result <= special_res;
                            state  <= DONE;
                        end else begin
                            state  <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    quo <= quo_nxt;
                    rem <= rem_nxt;
                    cnt <= cnt + CNT_WIDTH'(1);
                    if (cnt == LAST_CNT) begin
                        result <= final_res;
                        state  <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign E_DivDone   = (state == DONE);
    assign E_DivStall  = ((state == IDLE) & E_DivStart & ~E_Flush) | (state == BUSY);
    assign E_DivResult = result;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: stimulus pushes expected result and completion cycle into a
// scoreboard queue, a negedge monitor pops and compares on every E_DivDone pulse.
module tb_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         E_DivStart;
    logic [1:0]   E_DivOp;
    logic [W-1:0] E_SrcA;
    logic [W-1:0] E_SrcB;
    logic         E_Flush;
    logic         E_DivStall;
    logic         E_DivDone;
    logic [W-1:0] E_DivResult;

    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

    typedef struct {
        logic [W-1:0] result;
        int           cycle;
        string        name;
    } exp_t;

    exp_t scoreboard[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    div_unit #(.DATA_WIDTH(W), .CNT_WIDTH(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .E_DivStart (E_DivStart),
        .E_DivOp    (E_DivOp),
        .E_SrcA     (E_SrcA),
        .E_SrcB     (E_SrcB),
        .E_Flush    (E_Flush),
        .E_DivStall (E_DivStall),
        .E_DivDone  (E_DivDone),
        .E_DivResult(E_DivResult)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every completion must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (E_DivDone === 1'b1) begin
            if (scoreboard.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got result 0x%08h expected no pulse (cycle %0d)",
                         E_DivResult, cyc);
            end else begin
                exp_t e;
                e = scoreboard.pop_front();
                check({e.name, "_result"}, E_DivResult, e.result);
                check({e.name, "_cycle"}, W'(cyc), W'(e.cycle));
            end
        end
    end

    // Issue one divide and hold E_DivStart through its completion cycle, checking the
    // stall request every cycle. E_DivStart is left high; the caller decides what follows.
    task automatic do_div(input string name, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp, input bit special);
        int   lat;
        exp_t e;
        lat = special ? 1 : W + 1;
        @(posedge clk); #1;
        E_DivStart = 1'b1;
        E_DivOp    = op;
        E_SrcA     = a;
        E_SrcB     = b;
        e.result   = exp;
        e.cycle    = cyc + lat;
        e.name     = name;
        scoreboard.push_back(e);
        for (int k = 0; k <= lat; k++) begin
            @(negedge clk);
            check({name, "_stall"}, W'(E_DivStall), W'(k < lat));
            if (k == 1) begin
                // Operand changes after the start edge must be ignored.
                E_SrcA = 32'h1234_5678;
                E_SrcB = 32'h0000_0001;
            end
            if (k < lat) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            E_DivStart = 1'b0;
            E_Flush    = 1'b0;
            rst        = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; E_DivStart = 1'b0; E_DivOp = '0; E_SrcA = '0; E_SrcB = '0; E_Flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_stall", W'(E_DivStall), '0);
        check("reset_done", W'(E_DivDone), '0);
        check("reset_result", E_DivResult, '0);

        // Normal-latency arithmetic
        do_div("divu_100_7",  OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0);            idle(1);
        do_div("remu_100_7",  OP_REMU, 32'd100, 32'd7, 32'd2, 1'b0);             idle(1);
        do_div("div_m7_2",    OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0); idle(1);
        do_div("rem_m7_2",    OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0); idle(1);
        do_div("rem_7_m2",    OP_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0);        idle(1);
        do_div("divu_fffe_2", OP_DIVU, 32'hFFFF_FFFE, 32'd2, 32'h7FFF_FFFF, 1'b0); idle(1);
        do_div("remu_ffff_10", OP_REMU, 32'hFFFF_FFFF, 32'd10, 32'd5, 1'b0);      idle(1);

        // Special cases complete one cycle after start
        do_div("div_5_0",     OP_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);       idle(1);
        do_div("remu_5_0",    OP_REMU, 32'd5, 32'd0, 32'd5, 1'b1);               idle(1);
        do_div("div_ovf",     OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1); idle(1);
        do_div("rem_ovf",     OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1); idle(1);

        // Flush in cycle 10 of a divide: no completion may follow
        @(posedge clk); #1;
        E_DivStart = 1'b1; E_DivOp = OP_DIVU; E_SrcA = 32'd100; E_SrcB = 32'd7;
        repeat (10) @(posedge clk);
        #1;
        E_Flush = 1'b1;
        @(negedge clk);
        check("flush_busy_stall", W'(E_DivStall), 32'd1);
        @(posedge clk); #1;
        E_Flush = 1'b0; E_DivStart = 1'b0;
        @(negedge clk);
        check("flush_after_stall", W'(E_DivStall), '0);
        check("flush_after_done", W'(E_DivDone), '0);
        idle(40);
        do_div("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 1'b0);                  idle(1);

        // Flush together with start from IDLE must not launch a divide
        @(posedge clk); #1;
        E_DivStart = 1'b1; E_Flush = 1'b1; E_DivOp = OP_DIVU; E_SrcA = 32'd50; E_SrcB = 32'd5;
        @(negedge clk);
        check("flush_start_stall", W'(E_DivStall), '0);
        @(posedge clk); #1;
        E_DivStart = 1'b0; E_Flush = 1'b0;
        @(negedge clk);
        check("flush_start_idle_stall", W'(E_DivStall), '0);
        idle(40);

        // Reset in cycle 5 of a divide clears every output
        @(posedge clk); #1;
        E_DivStart = 1'b1; E_DivOp = OP_DIVU; E_SrcA = 32'd77; E_SrcB = 32'd7;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; E_DivStart = 1'b0;
        @(negedge clk);
        check("rst_busy_stall", W'(E_DivStall), '0);
        check("rst_busy_done", W'(E_DivDone), '0);
        check("rst_busy_result", E_DivResult, '0);
        idle(40);

        // Back-to-back with E_DivStart held: second starts the cycle after DONE
        do_div("b2b_first",  OP_DIVU, 32'd20, 32'd4, 32'd5, 1'b0);
        do_div("b2b_second", OP_DIVU, 32'd20, 32'd4, 32'd5, 1'b0);
        idle(5);

        check("scoreboard_drained", W'(scoreboard.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
